// File: rtl/exu_lsu_if.sv
// Single-outstanding req/gnt/rvalid data bus between the LSU (master) and memory (slave).
interface exu_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/exu_lsu.sv
// Load/store unit behind the EXU ALU stage: one bus access in flight, registered writeback.
// Optional macro LSU_MISALIGN_EXC_EN: misaligned H/W accesses raise o_err instead of issuing.
module exu_lsu #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mem_wen,
  input  logic        i_mem_ren,
  input  logic [31:0] i_mem_addr,
  input  logic [2:0]  i_mem_funct3,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_result,
  input  logic        i_rd_wen,
  input  logic [4:0]  i_rd_addr,
  output logic        o_stall,
  exu_lsu_if.master   bus,
  output logic        o_wb_en,
  output logic [4:0]  o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic        o_err
);
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, complete, timeout, misalign_err, misalign;

  logic [31:0] addr_q, wdata_q, wdata_d, wb_data_q, ld_data;
  logic [2:0]  f3_q;
  logic [3:0]  be_q, be_d;
  logic        we_q, rd_wen_q, wb_en_q, err_q;
  logic [4:0]  rd_addr_q, wb_addr_q;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

`ifdef LSU_MISALIGN_EXC_EN
  assign misalign = ((i_mem_funct3[1:0] == 2'b01) && i_mem_addr[0]) ||
                    (i_mem_funct3[1] && (i_mem_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Completion in the last allowed cycle takes precedence over the timeout.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    accept       = 1'b0;
    complete     = 1'b0;
    timeout      = 1'b0;
    misalign_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_mem_wen || i_mem_ren) begin
          if (misalign) begin
            misalign_err = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = S_REQ;
            cnt_d   = '0;
          end
        end
      end
      S_REQ: begin
        if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (bus.gnt) state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rvalid) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // funct3[1] set means word (covers the undefined encodings too).
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = i_store_data;
    case (i_mem_funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << i_mem_addr[1:0];
        wdata_d = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        be_d    = i_mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{i_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = bus.rdata[7:0];
      2'b01:   ld_byte = bus.rdata[15:8];
      2'b10:   ld_byte = bus.rdata[23:16];
      default: ld_byte = bus.rdata[31:24];
    endcase
    ld_half = addr_q[1] ? bus.rdata[31:16] : bus.rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = bus.rdata;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q    <= '0;
      f3_q      <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rd_wen_q  <= 1'b0;
      rd_addr_q <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q   <= timeout | misalign_err;
      wb_en_q <= 1'b0;
      if (accept) begin
        addr_q    <= i_mem_addr;
        f3_q      <= i_mem_funct3;
        be_q      <= be_d;
        wdata_q   <= wdata_d;
        we_q      <= i_mem_wen;
        rd_wen_q  <= i_rd_wen;
        rd_addr_q <= i_rd_addr;
      end
      if (state_q == S_IDLE && !(i_mem_wen || i_mem_ren)) begin
        wb_en_q   <= i_rd_wen;
        wb_addr_q <= i_rd_addr;
        wb_data_q <= i_result;
      end
      if (complete && !we_q) begin
        wb_en_q   <= rd_wen_q;
        wb_addr_q <= rd_addr_q;
        wb_data_q <= ld_data;
      end
    end
  end

  assign o_stall    = (state_q != S_IDLE);
  assign bus.req    = (state_q == S_REQ);
  assign bus.we     = we_q;
  assign bus.addr   = {addr_q[31:2], 2'b00};
  assign bus.be     = be_q;
  assign bus.wdata  = wdata_q;
  assign o_wb_en    = wb_en_q;
  assign o_wb_addr  = wb_addr_q;
  assign o_wb_data  = wb_data_q;
  assign o_err      = err_q;
endmodule

// File: tb/tb_exu_lsu.sv
// Self-checking bench for exu_lsu: directed spec cases plus randomized traffic vs. a byte-level model.
module tb_exu_lsu;
  localparam int TIMEOUT_CYC = 16;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_mem_wen, i_mem_ren, i_rd_wen;
  logic [31:0] i_mem_addr, i_store_data, i_result;
  logic [2:0]  i_mem_funct3;
  logic [4:0]  i_rd_addr;
  logic        o_stall, o_wb_en, o_err;
  logic [4:0]  o_wb_addr;
  logic [31:0] o_wb_data;
  int          checks = 0;
  int          errors = 0;

  exu_lsu_if bus();

  exu_lsu #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_mem_wen(i_mem_wen), .i_mem_ren(i_mem_ren), .i_mem_addr(i_mem_addr),
    .i_mem_funct3(i_mem_funct3), .i_store_data(i_store_data), .i_result(i_result),
    .i_rd_wen(i_rd_wen), .i_rd_addr(i_rd_addr), .o_stall(o_stall), .bus(bus),
    .o_wb_en(o_wb_en), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: access width in bytes, byte offset, and lane arithmetic.
  function automatic int m_nbytes(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic int m_off(input logic [2:0] f3, input logic [31:0] addr);
    int n;
    n = m_nbytes(f3);
    return ((addr % 4) / n) * n;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    return 4'(((1 << m_nbytes(f3)) - 1) << m_off(f3, addr));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    int n;
    n = m_nbytes(f3);
    if (n == 1) return (d % 256) * 32'h0101_0101;
    if (n == 2) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
    int n;
    logic [31:0] v, span;
    n = m_nbytes(f3);
    if (n == 4) return rd;
    span = 32'(1) << (8 * n);
    v = (rd >> (8 * m_off(f3, addr))) % span;
    if ((f3 == 3'd0 || f3 == 3'd1) && v >= span / 2) v = v - span;
    return v;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_mem_wen = 1'b0; i_mem_ren = 1'b0; i_mem_addr = '0; i_mem_funct3 = '0;
    i_store_data = '0; i_result = '0; i_rd_wen = 1'b0; i_rd_addr = '0;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
  endtask

  // Full access: gnt after gd extra REQ cycles, rvalid after rdl extra RESP cycles; ends in the wb cycle.
  task automatic do_mem(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [31:0] rdat, input logic rdw,
                        input logic [4:0] rd, input int gd, input int rdl, input string nm);
    logic [31:0] e_addr, e_wd, e_ld;
    logic [3:0]  e_be;
    logic        e_wb;
    e_addr = (addr / 4) * 4;
    e_be   = m_be(f3, addr);
    e_wd   = m_wdata(f3, sd);
    e_ld   = m_load(f3, addr, rdat);
    e_wb   = !we && rdw;
    i_mem_wen = we; i_mem_ren = we ? 1'($urandom_range(0, 1)) : 1'b1;
    i_mem_addr = addr; i_mem_funct3 = f3; i_store_data = sd;
    i_rd_wen = rdw; i_rd_addr = rd; i_result = $urandom;
    step();
    for (int k = 0; k <= gd; k++) begin
      bus.gnt = (k == gd);
      checks++; if (bus.req !== 1'b1 || o_stall !== 1'b1) begin errors++; $display("FAIL %s req/stall: got %b/%b exp 1/1", nm, bus.req, o_stall); end
      checks++; if (bus.addr !== e_addr) begin errors++; $display("FAIL %s bus_addr: got %h exp %h", nm, bus.addr, e_addr); end
      checks++; if (bus.we !== we || bus.be !== e_be) begin errors++; $display("FAIL %s we/be: got %b/%b exp %b/%b", nm, bus.we, bus.be, we, e_be); end
      if (we) begin
        checks++; if (bus.wdata !== e_wd) begin errors++; $display("FAIL %s wdata: got %h exp %h", nm, bus.wdata, e_wd); end
      end
      checks++; if (o_wb_en !== 1'b0 || o_err !== 1'b0) begin errors++; $display("FAIL %s wb/err in REQ: got %b/%b exp 0/0", nm, o_wb_en, o_err); end
      step();
    end
    bus.gnt = 1'b0;
    for (int k = 0; k <= rdl; k++) begin
      bus.rvalid = (k == rdl);
      bus.rdata  = (k == rdl) ? rdat : $urandom;
      checks++; if (bus.req !== 1'b0 || o_stall !== 1'b1) begin errors++; $display("FAIL %s resp req/stall: got %b/%b exp 0/1", nm, bus.req, o_stall); end
      step();
    end
    idle_inputs();
    checks++; if (o_stall !== 1'b0 || o_err !== 1'b0 || o_wb_en !== e_wb) begin errors++; $display("FAIL %s done stall/err/wb: got %b/%b/%b exp 0/0/%b", nm, o_stall, o_err, o_wb_en, e_wb); end
    if (e_wb) begin
      checks++; if (o_wb_addr !== rd || o_wb_data !== e_ld) begin errors++; $display("FAIL %s wb: got rd%0d %h exp rd%0d %h", nm, o_wb_addr, o_wb_data, rd, e_ld); end
    end
    $display("txn %s we=%b f3=%0d addr=%h gd=%0d rdl=%0d wb=%b data=%h", nm, we, f3, addr, gd, rdl, o_wb_en, o_wb_data);
  endtask

  task automatic alu_op(input logic rdw, input logic [4:0] rd, input logic [31:0] res, input string nm);
    i_mem_wen = 1'b0; i_mem_ren = 1'b0; i_rd_wen = rdw; i_rd_addr = rd; i_result = res;
    step();
    i_rd_wen = 1'b0;
    checks++; if (o_wb_en !== rdw || o_stall !== 1'b0) begin errors++; $display("FAIL %s wb_en/stall: got %b/%b exp %b/0", nm, o_wb_en, o_stall, rdw); end
    if (rdw) begin
      checks++; if (o_wb_addr !== rd || o_wb_data !== res) begin errors++; $display("FAIL %s wb: got rd%0d %h exp rd%0d %h", nm, o_wb_addr, o_wb_data, rd, res); end
    end
    $display("txn %s alu rd=%0d res=%h wb=%b", nm, rd, res, o_wb_en);
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rst = 1'b1;
    step(); step();
    i_rst = 1'b0;
    checks++; if (o_stall !== 0 || bus.req !== 0 || o_wb_en !== 0 || o_err !== 0) begin errors++; $display("FAIL reset ctl: got stall%b req%b wb%b err%b exp 0000", o_stall, bus.req, o_wb_en, o_err); end
    checks++; if (bus.addr !== 0 || bus.be !== 0 || bus.wdata !== 0 || bus.we !== 0 || o_wb_data !== 0 || o_wb_addr !== 0) begin errors++; $display("FAIL reset data: got addr %h be %b wd %h wbd %h exp 0", bus.addr, bus.be, bus.wdata, o_wb_data); end
    step();
    checks++; if (o_stall !== 0 || o_wb_en !== 0) begin errors++; $display("FAIL reset idle: got stall%b wb%b exp 00", o_stall, o_wb_en); end
  endtask

  task automatic test_directed();
    do_mem(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1, 5'd5, 0, 0, "lw");
    do_mem(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 1'b1, 5'd6, 0, 0, "lb");
    do_mem(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 1'b1, 5'd6, 0, 0, "lbu");
    do_mem(1'b0, 3'b101, 32'h102, 32'h0, 32'h80FFFFFF, 1'b1, 5'd6, 0, 0, "lhu");
    do_mem(1'b1, 3'b000, 32'h101, 32'h12345678, 32'h0, 1'b1, 5'd3, 0, 0, "sb");
    do_mem(1'b0, 3'b010, 32'h200, 32'h0, 32'hCAFE0001, 1'b1, 5'd9, 3, 0, "gnt_wait3");
    do_mem(1'b0, 3'b010, 32'h204, 32'h0, 32'h0BADF00D, 1'b1, 5'd10, 0, 14, "last_cyc_resp");
    do_mem(1'b0, 3'b001, 32'h206, 32'h0, 32'h8001_7FFF, 1'b1, 5'd11, 14, 0, "last_cyc_gnt");
  endtask

  task automatic test_timeout(input logic gnt_first, input string nm);
    i_mem_ren = 1'b1; i_mem_funct3 = 3'b010; i_mem_addr = 32'h300; i_rd_wen = 1'b1; i_rd_addr = 5'd4;
    step();
    idle_inputs();
    for (int k = 0; k < TIMEOUT_CYC; k++) begin
      bus.gnt = gnt_first && (k == 0);
      checks++; if (o_stall !== 1'b1 || o_err !== 1'b0) begin errors++; $display("FAIL %s wait cyc%0d stall/err: got %b/%b exp 1/0", nm, k, o_stall, o_err); end
      step();
    end
    bus.gnt = 1'b0;
    checks++; if (o_err !== 1'b1 || o_stall !== 1'b0 || o_wb_en !== 1'b0 || bus.req !== 1'b0) begin errors++; $display("FAIL %s abort err/stall/wb/req: got %b/%b/%b/%b exp 1/0/0/0", nm, o_err, o_stall, o_wb_en, bus.req); end
    step();
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL %s err pulse: got %b exp 0", nm, o_err); end
    $display("txn %s timeout", nm);
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    i_rd_wen = 1'b1; i_rd_addr = 5'd7; i_result = 32'h55;
    step();
    checks++; if (o_wb_en !== 1'b1 || o_wb_addr !== 5'd7 || o_wb_data !== 32'h55) begin errors++; $display("FAIL b2b alu wb: got %b rd%0d %h exp 1 rd7 00000055", o_wb_en, o_wb_addr, o_wb_data); end
    do_mem(1'b0, 3'b010, 32'h400, 32'h0, 32'h1234ABCD, 1'b1, 5'd8, 0, 0, "b2b_lw");
    r = $urandom;
    alu_op(1'b1, 5'd9, r, "b2b_alu_after");
    alu_op(1'b1, 5'd0, 32'hA5A5A5A5, "rd0");
    alu_op(1'b0, 5'd12, 32'h1, "no_rdwen");
  endtask

  task automatic test_reset_mid();
    i_mem_ren = 1'b1; i_mem_funct3 = 3'b010; i_mem_addr = 32'h500; i_rd_wen = 1'b1; i_rd_addr = 5'd2;
    step();
    idle_inputs();
    bus.gnt = 1'b1;
    step();
    bus.gnt = 1'b0; i_rst = 1'b1;
    step();
    i_rst = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h77778888;
    checks++; if (bus.req !== 0 || o_stall !== 0) begin errors++; $display("FAIL rst_resp after reset req/stall: got %b/%b exp 0/0", bus.req, o_stall); end
    step();
    bus.rvalid = 1'b0;
    checks++; if (o_wb_en !== 0 || o_err !== 0 || o_stall !== 0) begin errors++; $display("FAIL rst_resp late rvalid wb/err/stall: got %b/%b/%b exp 0/0/0", o_wb_en, o_err, o_stall); end
    i_mem_wen = 1'b1; i_mem_funct3 = 3'b010; i_mem_addr = 32'h504;
    step();
    idle_inputs();
    checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL rst_req issue: got req %b exp 1", bus.req); end
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    checks++; if (bus.req !== 1'b0 || o_err !== 1'b0) begin errors++; $display("FAIL rst_req drop req/err: got %b/%b exp 0/0", bus.req, o_err); end
    $display("txn reset_mid");
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_EXC_EN
    i_mem_ren = 1'b1; i_mem_funct3 = 3'b010; i_mem_addr = 32'h102; i_rd_wen = 1'b1; i_rd_addr = 5'd5;
    step();
    idle_inputs();
    checks++; if (o_err !== 1'b1 || bus.req !== 1'b0 || o_stall !== 1'b0 || o_wb_en !== 1'b0) begin errors++; $display("FAIL misalign err/req/stall/wb: got %b/%b/%b/%b exp 1/0/0/0", o_err, bus.req, o_stall, o_wb_en); end
    step();
    checks++; if (o_err !== 1'b0 || bus.req !== 1'b0) begin errors++; $display("FAIL misalign after err/req: got %b/%b exp 0/0", o_err, bus.req); end
    $display("txn misalign lw 0x102");
`else
    do_mem(1'b0, 3'b010, 32'h102, 32'h0, 32'hFEEDC0DE, 1'b1, 5'd5, 0, 0, "lw_unaligned");
    do_mem(1'b0, 3'b001, 32'h103, 32'h0, 32'h8000_1234, 1'b1, 5'd6, 1, 1, "lh_unaligned");
`endif
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] addr;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        alu_op(1'($urandom_range(0, 1)), 5'($urandom), $urandom, "rnd_alu");
      end else begin
        f3   = 3'($urandom);
        addr = $urandom;
`ifdef LSU_MISALIGN_EXC_EN
        addr = addr - (addr % m_nbytes(f3));
`endif
        do_mem(1'($urandom_range(0, 1)), f3, addr, $urandom, $urandom, 1'($urandom_range(0, 1)),
               5'($urandom), $urandom_range(0, 5), $urandom_range(0, 5), "rnd_mem");
      end
    end
    idle_inputs();
  endtask

  initial begin
    i_rst = 1'b1;
    idle_inputs();
    test_reset();
    test_directed();
    test_timeout(1'b0, "to_req");
    test_timeout(1'b1, "to_resp");
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
